// File: rtl/frame_scanout_if.sv
// Scan-out bus between frame_scanout and the frame buffer / drawing side.
// The master modport is the scan-out engine; the slave modport is its environment.
interface frame_scanout_if #(
   parameter int unsigned ADDR_WIDTH = 19
);
   logic [ADDR_WIDTH-1:0] read_addr;
   logic                  read_data;
   logic                  swap_request;
   logic                  swap;
   logic                  hsync;
   logic                  vsync;
   logic                  active;
   logic                  pixel;
   logic                  vblank;

   modport master (
      output read_addr,
      output swap,
      output hsync,
      output vsync,
      output active,
      output pixel,
      output vblank,
      input  read_data,
      input  swap_request
   );

   modport slave (
      input  read_addr,
      input  swap,
      input  hsync,
      input  vsync,
      input  active,
      input  pixel,
      input  vblank,
      output read_data,
      output swap_request
   );
endinterface

// File: rtl/frame_scanout.sv
// VGA raster scan-out: walks the frame buffer linearly, generates sync timing and
// issues one buffer swap per frame at the start of vertical blanking.
module frame_scanout #(
   parameter int unsigned HOR_ACTIVE_PIXELS = 640,
   parameter int unsigned HOR_FRONT_PORCH   = 16,
   parameter int unsigned HOR_SYNC          = 96,
   parameter int unsigned HOR_BACK_PORCH    = 48,
   parameter int unsigned VER_ACTIVE_PIXELS = 480,
   parameter int unsigned VER_FRONT_PORCH   = 10,
   parameter int unsigned VER_SYNC          = 2,
   parameter int unsigned VER_BACK_PORCH    = 33
) (
   input  logic            clk,
   input  logic            rst_n,
   frame_scanout_if.master bus
);

   localparam int unsigned ADDR_WIDTH   = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);
   localparam int unsigned H_TOTAL      = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
   localparam int unsigned V_TOTAL      = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
   localparam int unsigned H_W          = $clog2(H_TOTAL);
   localparam int unsigned V_W          = $clog2(V_TOTAL);
   localparam int unsigned H_SYNC_START = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + HOR_SYNC;
   localparam int unsigned V_SYNC_START = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + VER_SYNC;

   logic [H_W-1:0]        h_cnt;
   logic [V_W-1:0]        v_cnt;
   logic [ADDR_WIDTH-1:0] read_addr_q;
   logic                  swap_pending;
   logic                  swap_q;
   logic                  hsync_q;
   logic                  vsync_q;
   logic                  active_q;

   logic [31:0]           h_ext_c;
   logic [31:0]           v_ext_c;
   logic                  h_last_c;
   logic                  v_last_c;
   logic                  visible_c;
   logic                  hsync_n_c;
   logic                  vsync_n_c;
   logic                  service_c;
   logic                  swap_c;

   // Stage-0 decode of the raster position
   always_comb begin
      h_ext_c   = 32'(h_cnt);
      v_ext_c   = 32'(v_cnt);
      h_last_c  = (h_ext_c == H_TOTAL - 1);
      v_last_c  = (v_ext_c == V_TOTAL - 1);
      visible_c = (h_ext_c < HOR_ACTIVE_PIXELS) && (v_ext_c < VER_ACTIVE_PIXELS);
      hsync_n_c = !((h_ext_c >= H_SYNC_START) && (h_ext_c < H_SYNC_END));
      vsync_n_c = !((v_ext_c >= V_SYNC_START) && (v_ext_c < V_SYNC_END));
      // Single service point per frame: first cycle of vertical blanking
      service_c = (h_cnt == '0) && (v_ext_c == VER_ACTIVE_PIXELS);
      swap_c    = service_c && (swap_pending || bus.swap_request);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_cnt        <= '0;
         v_cnt        <= '0;
         read_addr_q  <= '0;
         swap_pending <= 1'b0;
         swap_q       <= 1'b0;
         hsync_q      <= 1'b1;
         vsync_q      <= 1'b1;
         active_q     <= 1'b0;
      end else begin
         if (h_last_c) begin
            h_cnt <= '0;
            v_cnt <= v_last_c ? '0 : v_cnt + V_W'(1);
         end else begin
            h_cnt <= h_cnt + H_W'(1);
         end

         // Linear address tracks visible pixels only, so no multiply is needed
         if (h_last_c && v_last_c) begin
            read_addr_q <= '0;
         end else if (visible_c) begin
            read_addr_q <= read_addr_q + ADDR_WIDTH'(1);
         end

         swap_pending <= (swap_pending || bus.swap_request) && !service_c;
         swap_q       <= swap_c;

         // One-cycle delay aligns timing with the frame buffer read latency
         hsync_q  <= hsync_n_c;
         vsync_q  <= vsync_n_c;
         active_q <= visible_c;
      end
   end

   assign bus.read_addr = read_addr_q;
   assign bus.swap      = swap_q;
   assign bus.hsync     = hsync_q;
   assign bus.vsync     = vsync_q;
   assign bus.active    = active_q;
   assign bus.pixel     = bus.read_data && active_q;
   assign bus.vblank    = (v_ext_c >= VER_ACTIVE_PIXELS);

endmodule

// File: tb/tb_frame_scanout.sv
// Self-checking bench for frame_scanout with a reduced raster so several frames fit in a short run.
// A position-based model derives expected timing, addresses and swap points from the raster rules.
module tb_frame_scanout;

   localparam int HA  = 16;
   localparam int HFP = 2;
   localparam int HS  = 3;
   localparam int HBP = 3;
   localparam int VA  = 12;
   localparam int VFP = 2;
   localparam int VS  = 2;
   localparam int VBP = 3;
   localparam int HT  = HA + HFP + HS + HBP;
   localparam int VT  = VA + VFP + VS + VBP;
   localparam int FT  = HT * VT;
   localparam int SERVE = VA * HT;
   localparam int unsigned AW = $clog2(HA * VA);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   frame_scanout_if #(.ADDR_WIDTH(AW)) bus ();

   frame_scanout #(
      .HOR_ACTIVE_PIXELS(HA),
      .HOR_FRONT_PORCH  (HFP),
      .HOR_SYNC         (HS),
      .HOR_BACK_PORCH   (HBP),
      .VER_ACTIVE_PIXELS(VA),
      .VER_FRONT_PORCH  (VFP),
      .VER_SYNC         (VS),
      .VER_BACK_PORCH   (VBP)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model state: stage-0 position of the current cycle and frames since reset
   int pos   = 0;
   int frame = 0;
   logic exp_hsync, exp_vsync, exp_active, exp_pixel, exp_vblank;
   int   exp_addr;
   int   req_q[$];
   int   swap_log[$];

   // Advance one clock: frame-buffer model, position model and event logs
   task automatic tick();
      logic nd;
      int   q, hq, vq, hp, vp;
      bit   counting;
      nd = bus.read_addr[0];
      q  = frame * FT + pos;
      hq = pos % HT;
      vq = pos / HT;
      @(posedge clk);
      counting = (rst_n === 1'b1);
      if (counting) begin
         if (bus.swap_request === 1'b1) req_q.push_back(q);
         pos = (pos + 1) % FT;
         if (pos == 0) frame++;
      end else begin
         pos   = 0;
         frame = 0;
         req_q.delete();
         swap_log.delete();
      end
      #1;
      bus.read_data    = nd;
      bus.swap_request = 1'b0;
      #1;
      if (counting && bus.swap === 1'b1) swap_log.push_back(q);
      if (!counting) begin
         exp_hsync  = 1'b1;
         exp_vsync  = 1'b1;
         exp_active = 1'b0;
         exp_pixel  = 1'b0;
      end else begin
         exp_hsync  = !(hq >= HA + HFP && hq < HA + HFP + HS);
         exp_vsync  = !(vq >= VA + VFP && vq < VA + VFP + VS);
         exp_active = (hq < HA) && (vq < VA);
         exp_pixel  = exp_active && (((vq * HA + hq) % 2) == 1);
      end
      hp = pos % HT;
      vp = pos / HT;
      exp_addr   = (vp < VA) ? vp * HA + ((hp < HA) ? hp : HA) : HA * VA;
      exp_vblank = (vp >= VA);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic run_to(input int p);
      for (int i = 0; i < FT && pos != p; i++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      bus.read_data = 1'b1;
      #1;
      checks++; if (bus.hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", bus.hsync); end
      checks++; if (bus.vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", bus.vsync); end
      checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", bus.active); end
      checks++; if (bus.swap !== 1'b0) begin errors++; $display("FAIL reset_swap got %b want 0", bus.swap); end
      checks++; if (bus.pixel !== 1'b0) begin errors++; $display("FAIL reset_pixel got %b want 0", bus.pixel); end
      checks++; if (bus.read_addr !== AW'(0)) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.read_addr); end
      checks++; if (bus.vblank !== 1'b0) begin errors++; $display("FAIL reset_vblank got %b want 0", bus.vblank); end
      rst_n = 1'b1;
   endtask

   task automatic test_scan();
      int   first_hfall = -1, hper = -1, hlow = -1, hstart = -1;
      int   vfall = -1, vper = -1, vlow = -1;
      logic ph = 1'b1, pv = 1'b1;
      do_reset();
      for (int n = 1; n <= 2 * FT + HT; n++) begin
         tick();
         checks++; if (bus.hsync !== exp_hsync) begin errors++; $display("FAIL scan_hsync n=%0d got %b want %b", n, bus.hsync, exp_hsync); end
         checks++; if (bus.vsync !== exp_vsync) begin errors++; $display("FAIL scan_vsync n=%0d got %b want %b", n, bus.vsync, exp_vsync); end
         checks++; if (bus.active !== exp_active) begin errors++; $display("FAIL scan_active n=%0d got %b want %b", n, bus.active, exp_active); end
         checks++; if (bus.pixel !== exp_pixel) begin errors++; $display("FAIL scan_pixel n=%0d got %b want %b", n, bus.pixel, exp_pixel); end
         checks++; if (bus.read_addr !== AW'(exp_addr)) begin errors++; $display("FAIL scan_addr n=%0d got %0d want %0d", n, bus.read_addr, exp_addr); end
         checks++; if (bus.vblank !== exp_vblank) begin errors++; $display("FAIL scan_vblank n=%0d got %b want %b", n, bus.vblank, exp_vblank); end
         if (pos == (VA - 1) * HT + HA - 1) begin
            checks++; if (bus.read_addr !== AW'(HA * VA - 1)) begin errors++; $display("FAIL last_addr got %0d want %0d", bus.read_addr, HA * VA - 1); end
         end
         if (pos == 0) begin
            checks++; if (bus.read_addr !== AW'(0)) begin errors++; $display("FAIL wrap_addr got %0d want 0", bus.read_addr); end
         end
         if (ph && !bus.hsync) begin
            if (first_hfall < 0) first_hfall = n;
            else if (hper < 0) hper = n - hstart;
            hstart = n;
         end
         if (!ph && bus.hsync && hlow < 0) hlow = n - hstart;
         if (pv && !bus.vsync) begin
            if (vfall >= 0 && vper < 0) vper = n - vfall;
            vfall = n;
         end
         if (!pv && bus.vsync && vlow < 0) vlow = n - vfall;
         ph = bus.hsync;
         pv = bus.vsync;
      end
      checks++; if (first_hfall != HA + HFP + 1) begin errors++; $display("FAIL hsync_first_fall got %0d want %0d", first_hfall, HA + HFP + 1); end
      checks++; if (hlow != HS) begin errors++; $display("FAIL hsync_width got %0d want %0d", hlow, HS); end
      checks++; if (hper != HT) begin errors++; $display("FAIL hsync_period got %0d want %0d", hper, HT); end
      checks++; if (vlow != VS * HT) begin errors++; $display("FAIL vsync_width got %0d want %0d", vlow, VS * HT); end
      checks++; if (vper != FT) begin errors++; $display("FAIL frame_period got %0d want %0d", vper, FT); end
   endtask

   task automatic test_swap_single();
      int p;
      p = int'($urandom_range(SERVE - 1, 1));
      do_reset();
      run_to(p);
      bus.swap_request = 1'b1;
      for (int i = 0; i < 2 * FT + HT; i++) tick();
      checks++;
      if (swap_log.size() != 1) begin
         errors++; $display("FAIL single_swap_count got %0d want 1 (req at %0d)", swap_log.size(), p);
      end else begin
         checks++; if (swap_log[0] != SERVE) begin errors++; $display("FAIL single_swap_pos got %0d want %0d", swap_log[0], SERVE); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_to(SERVE);
      bus.swap_request = 1'b1;
      run_to(SERVE + 5);
      bus.swap_request = 1'b1;
      for (int i = 0; i < 2 * FT; i++) tick();
      checks++;
      if (swap_log.size() != 2) begin
         errors++; $display("FAIL b2b_swap_count got %0d want 2", swap_log.size());
      end else begin
         checks++; if (swap_log[0] != SERVE) begin errors++; $display("FAIL b2b_first got %0d want %0d", swap_log[0], SERVE); end
         checks++; if (swap_log[1] != FT + SERVE) begin errors++; $display("FAIL b2b_second got %0d want %0d", swap_log[1], FT + SERVE); end
      end
   endtask

   task automatic test_multi_request();
      int p1, p2, p3;
      p1 = int'($urandom_range(SERVE / 3, 1));
      p2 = int'($urandom_range(2 * SERVE / 3, SERVE / 3 + 1));
      p3 = int'($urandom_range(SERVE, 2 * SERVE / 3 + 1));
      do_reset();
      run_to(p1); bus.swap_request = 1'b1;
      run_to(p2); bus.swap_request = 1'b1;
      run_to(p3); bus.swap_request = 1'b1;
      for (int i = 0; i < FT + HT; i++) tick();
      checks++;
      if (swap_log.size() != 1) begin
         errors++; $display("FAIL multi_swap_count got %0d want 1", swap_log.size());
      end else begin
         checks++; if (swap_log[0] != SERVE) begin errors++; $display("FAIL multi_swap_pos got %0d want %0d", swap_log[0], SERVE); end
      end
   endtask

   task automatic test_reset_midframe();
      int p;
      p = int'($urandom_range(FT / 2 - 1, 1));
      do_reset();
      run_to(p);
      bus.swap_request = 1'b1;
      run_to(FT / 2);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin errors++; $display("FAIL midreset_sync got %b%b want 11", bus.hsync, bus.vsync); end
         checks++; if (bus.active !== 1'b0 || bus.pixel !== 1'b0) begin errors++; $display("FAIL midreset_video got %b%b want 00", bus.active, bus.pixel); end
         checks++; if (bus.swap !== 1'b0) begin errors++; $display("FAIL midreset_swap got %b want 0", bus.swap); end
         checks++; if (bus.read_addr !== AW'(0)) begin errors++; $display("FAIL midreset_addr got %0d want 0", bus.read_addr); end
      end
      rst_n = 1'b1;
      for (int n = 1; n <= FT + HT; n++) begin
         tick();
         checks++; if (bus.read_addr !== AW'(exp_addr)) begin errors++; $display("FAIL restart_addr n=%0d got %0d want %0d", n, bus.read_addr, exp_addr); end
         checks++; if (bus.hsync !== exp_hsync || bus.active !== exp_active) begin errors++; $display("FAIL restart_timing n=%0d got %b%b want %b%b", n, bus.hsync, bus.active, exp_hsync, exp_active); end
      end
      checks++; if (swap_log.size() != 0) begin errors++; $display("FAIL restart_swap_count got %0d want 0", swap_log.size()); end
   endtask

   task automatic test_random();
      int exp_q[$];
      int lastq, s;
      bit hit;
      do_reset();
      for (int i = 0; i < 5 * FT; i++) begin
         tick();
         if ($urandom_range(149, 0) == 0) bus.swap_request = 1'b1;
      end
      tick();
      // A serve point swaps iff some request landed since the previous serve point
      lastq = frame * FT + pos - 1;
      for (int f = 0; SERVE + f * FT <= lastq; f++) begin
         s   = SERVE + f * FT;
         hit = 1'b0;
         foreach (req_q[i]) if (req_q[i] <= s && req_q[i] > s - FT) hit = 1'b1;
         if (hit) exp_q.push_back(s);
      end
      checks++;
      if (swap_log.size() != exp_q.size()) begin
         errors++; $display("FAIL random_swap_count got %0d want %0d", swap_log.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++; if (swap_log[i] != exp_q[i]) begin errors++; $display("FAIL random_swap_pos[%0d] got %0d want %0d", i, swap_log[i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      bus.read_data    = 1'b0;
      bus.swap_request = 1'b0;
      test_reset();
      test_scan();
      test_swap_single();
      test_back_to_back();
      test_multi_request();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
